// File: rtl/universal_register.sv
// WIDTH-bit universal register: load, shift, rotate, increment and decrement, updated on the falling clock edge.
// carry_out records the carry, borrow or shifted-out bit; zero flags q == 0 combinationally.
module universal_register #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             w,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   inc_sum;

  assign op      = mode_e'(mode);
  assign inc_sum = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if (reset) begin
      q_d     = RESET_VALUE;
      carry_d = 1'b0;
    end else if (w) begin
      unique case (op)
        MODE_HOLD: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
        MODE_LOAD: begin
          q_d     = d;
          carry_d = 1'b0;
        end
        MODE_SHL: begin
          q_d     = {q_q[WIDTH-2:0], serial_in};
          carry_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d     = {serial_in, q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        MODE_ROL: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          carry_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d     = {q_q[0], q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        MODE_INC: begin
          q_d     = inc_sum[WIDTH-1:0];
          carry_d = inc_sum[WIDTH];
        end
        MODE_DEC: begin
          // Borrow only when wrapping from zero to all ones.
          q_d     = q_q - {{(WIDTH-1){1'b0}}, 1'b1};
          carry_d = (q_q == '0);
        end
        default: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  // Reset is synchronous; all state moves on the falling edge.
  always_ff @(negedge clk) begin
    q_q     <= q_d;
    carry_q <= carry_d;
  end

  assign q         = q_q;
  assign carry_out = carry_q;
  assign zero      = (q_q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register: hand-computed vectors checked with immediate assertions.
// A second instance verifies a non-zero RESET_VALUE.
module tb_universal_register;

  localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010, M_SHR = 3'b011,
                         M_ROL  = 3'b100, M_ROR  = 3'b101, M_INC = 3'b110, M_DEC = 3'b111;

  logic       clk;
  logic       reset;
  logic [7:0] d;
  logic       w;
  logic [2:0] mode;
  logic       serial_in;
  logic [7:0] q, q_rv;
  logic       carry_out, carry_rv;
  logic       zero, zero_rv;

  int total = 0;
  int bad   = 0;

  universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .d(d), .w(w), .mode(mode), .serial_in(serial_in),
    .q(q), .carry_out(carry_out), .zero(zero)
  );

  universal_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut_rv (
    .clk(clk), .reset(reset), .d(d), .w(w), .mode(mode), .serial_in(serial_in),
    .q(q_rv), .carry_out(carry_rv), .zero(zero_rv)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Drive one operation, let it be sampled by the next falling edge, then settle.
  task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] m,
                               input logic [7:0] dv, input logic si);
    reset     = rst;
    w         = we;
    mode      = m;
    d         = dv;
    serial_in = si;
    @(negedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] eq, input logic ec, input logic ez);
    checkValue({tag, ".q"}, q, eq);
    checkValue({tag, ".carry"}, {7'd0, carry_out}, {7'd0, ec});
    checkValue({tag, ".zero"}, {7'd0, zero}, {7'd0, ez});
  endtask

  initial begin
    reset = 1'b1; w = 1'b0; mode = M_HOLD; d = 8'h00; serial_in = 1'b0;

    // Scenario 1: reset
    applyStimulus(1'b1, 1'b0, M_HOLD, 8'h00, 1'b0);
    checkOutput("reset", 8'h00, 1'b0, 1'b1);
    checkValue("reset_rv.q", q_rv, 8'hA5);
    checkValue("reset_rv.zero", {7'd0, zero_rv}, 8'h00);

    // Scenario 2: load gated by w
    applyStimulus(1'b0, 1'b0, M_LOAD, 8'h3C, 1'b0);
    checkOutput("load_w0", 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, M_LOAD, 8'h3C, 1'b0);
    checkOutput("load_w1", 8'h3C, 1'b0, 1'b0);

    // Scenario 3: shifts and rotates
    applyStimulus(1'b0, 1'b1, M_LOAD, 8'h81, 1'b0);
    checkOutput("load81", 8'h81, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, M_SHL, 8'h00, 1'b0);
    checkOutput("shl", 8'h02, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, M_SHR, 8'h00, 1'b1);
    checkOutput("shr", 8'h81, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, M_ROR, 8'h00, 1'b0);
    checkOutput("ror", 8'hC0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, M_ROL, 8'h00, 1'b0);
    checkOutput("rol", 8'h81, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, M_HOLD, 8'hFF, 1'b1);
    checkOutput("hold_w1", 8'h81, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, M_INC, 8'hFF, 1'b1);
    checkOutput("inc_w0", 8'h81, 1'b1, 1'b0);

    // Scenario 4: increment/decrement wrap
    applyStimulus(1'b0, 1'b1, M_LOAD, 8'hFF, 1'b0);
    checkOutput("loadFF", 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, M_INC, 8'h00, 1'b0);
    checkOutput("inc_wrap", 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, M_DEC, 8'h00, 1'b0);
    checkOutput("dec_wrap", 8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, M_DEC, 8'h00, 1'b0);
    checkOutput("dec", 8'hFE, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, M_INC, 8'h00, 1'b0);
    checkOutput("inc", 8'hFF, 1'b0, 1'b0);

    // Scenario 5: reset beats a concurrent operation, no dead cycle afterwards
    applyStimulus(1'b0, 1'b1, M_LOAD, 8'h55, 1'b0);
    checkOutput("load55", 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
    checkOutput("reset_inc", 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, M_INC, 8'h00, 1'b0);
    checkOutput("inc_after_reset", 8'h01, 1'b0, 1'b0);

    // Scenario 6: only values present at the falling edge matter
    w = 1'b1; mode = M_LOAD; d = 8'hAA;
    @(posedge clk);
    #1;
    checkOutput("glitch_rise", 8'h01, 1'b0, 1'b0);
    w = 1'b0; mode = M_INC; d = 8'hBB;
    @(negedge clk);
    #1;
    checkOutput("glitch_fall_hold", 8'h01, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    w = 1'b1; mode = M_LOAD; d = 8'hAA;
    @(negedge clk);
    #1;
    checkOutput("glitch_fall_load", 8'hAA, 1'b0, 1'b0);
    mode = M_INC;
    @(posedge clk);
    #1;
    checkOutput("glitch_rise2", 8'hAA, 1'b0, 1'b0);
    mode = M_HOLD;
    @(negedge clk);
    #1;
    checkOutput("glitch_fall_hold2", 8'hAA, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width in bits; legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0, sets the WIDTH-bit value loaded into q by reset.
REQ-003 clk  input  1  single clock; all state updates on the falling edge of clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the falling edge of clk.
REQ-005 d  input  WIDTH  parallel load data.
REQ-006 w  input  1  write enable; 1 = execute the operation selected by mode, 0 = hold.
REQ-007 mode  input  3  operation select, encoded per REQ-012.
REQ-008 serial_in  input  1  bit shifted in by the SHL and SHR operations.
REQ-009 q  output  WIDTH  registered contents.
REQ-010 carry_out  output  1  registered carry, borrow or shifted-out bit.
REQ-011 zero  output  1  combinational flag, 1 when q == 0.

Function
REQ-012 The mode encoding SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 INC, 111 DEC.
REQ-013 With reset=0 and w=0, q and carry_out SHALL hold their values at the falling edge, regardless of mode, d and serial_in.
REQ-014 HOLD with w=1 SHALL leave q and carry_out unchanged.
REQ-015 LOAD with w=1 SHALL set q <= d and carry_out <= 0.
REQ-016 SHL SHALL set q <= {q[WIDTH-2:0], serial_in} and carry_out <= old q[WIDTH-1].
REQ-017 SHR SHALL set q <= {serial_in, q[WIDTH-1:1]} and carry_out <= old q[0].
REQ-018 ROL SHALL set q <= {q[WIDTH-2:0], q[WIDTH-1]} and carry_out <= old q[WIDTH-1].
REQ-019 ROR SHALL set q <= {q[0], q[WIDTH-1:1]} and carry_out <= old q[0].
REQ-020 INC SHALL set q <= (q + 1) mod 2^WIDTH, and carry_out <= 1 only when old q was all ones (wrap to 0); otherwise carry_out <= 0.
REQ-021 DEC SHALL set q <= (q - 1) mod 2^WIDTH, and carry_out <= 1 only when old q was 0 (wrap to all ones); otherwise carry_out <= 0.
REQ-022 Every operation SHALL take effect at the first falling edge at which it is sampled, with a latency of one edge and no pipeline.
REQ-023 Back-to-back operations on consecutive falling edges SHALL each use the q value produced by the previous edge.
REQ-024 zero SHALL track q combinationally, with no additional register delay.
REQ-025 Inputs SHALL be sampled only at falling edges; changes between falling edges, including at rising edges, SHALL have no effect.

Reset
REQ-026 When reset=1 at a falling edge, the block SHALL set q <= RESET_VALUE and carry_out <= 0, overriding w, mode and all data inputs.
REQ-027 If reset is asserted on the same edge as any operation, reset SHALL win and the operation SHALL be discarded.
REQ-028 On the first falling edge after reset deasserts, the block SHALL execute normally, with no dead cycle.
REQ-029 Before the first reset, q SHALL be treated as unknown, and the bench SHALL NOT check it.

Verification (WIDTH=8, RESET_VALUE=0 unless stated)
REQ-030 Scenario 1: reset=1 for one falling edge -> q=8'h00, carry_out=0, zero=1; with RESET_VALUE=8'hA5 -> q=8'hA5, zero=0.
REQ-031 Scenario 2: LOAD d=8'h3C with w=0 -> q unchanged; then the same LOAD with w=1 -> q=8'h3C, carry_out=0, zero=0.
REQ-032 Scenario 3: q=8'h81, then SHL with serial_in=0 -> q=8'h02, carry_out=1; then SHR with serial_in=1 -> q=8'h81, carry_out=0; then ROR -> q=8'hC0, carry_out=1.
REQ-033 Scenario 4: q=8'hFF, then INC -> q=8'h00, carry_out=1, zero=1; then DEC -> q=8'hFF, carry_out=1; then DEC -> q=8'hFE, carry_out=0.
REQ-034 Scenario 5: q=8'h55, then reset=1 on the same edge as INC with w=1 -> q=8'h00, carry_out=0; next edge INC with reset=0 -> q=8'h01.
REQ-035 Scenario 6: change d, mode and w between falling edges and around rising edges -> q changes only at falling edges, per REQ-025.
